// File: rtl/rv_pkg.sv
// Shared core package: default widths, reset PC and the fetch buffer entry layout.
package rv_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned INSTR_W = 32;
    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered head outputs, occupancy count and flush.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear_i,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             data_i,
    input  logic                         pop_i,
    output logic                         valid_o,
    output logic [WIDTH-1:0]             data_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             push_ok, pop_ok;

    assign pop_ok  = pop_i && !clear_i && (cnt_q != '0);
    assign push_ok = push_i && !clear_i && ((cnt_q != CW'(DEPTH)) || pop_ok);

    // Head register is loaded with whatever will sit at the read pointer next cycle.
    always_comb begin
        wr_d    = wr_q + PW'(push_ok);
        rd_d    = rd_q + PW'(pop_ok);
        cnt_d   = cnt_q + CW'(push_ok) - CW'(pop_ok);
        valid_d = (cnt_d != '0);
        head_d  = (push_ok && (wr_q == rd_d)) ? data_i : mem_q[rd_d];
        if (clear_i) begin
            wr_d    = '0;
            rd_d    = '0;
            cnt_d   = '0;
            valid_d = 1'b0;
            head_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            head_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_q] <= data_i;
            end
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            head_q  <= head_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = head_q;
    assign count_o = cnt_q;

endmodule

// File: rtl/rv_fetch_queue.sv
// Decoupled instruction fetch: credit-limited sequential requests, in-order responses, PC-tagged buffer.
// Optional FETCH_PERF_EN adds saturating stall and flush counters.
module rv_fetch_queue
    import rv_pkg::*;
#(
    parameter int unsigned     XLEN     = rv_pkg::XLEN,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(rv_pkg::RESET_PC)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 redirect_valid,
    input  logic [XLEN-1:0]      redirect_pc,
    output logic                 imem_req_valid,
    input  logic                 imem_req_ready,
    output logic [XLEN-1:0]      imem_req_addr,
    input  logic                 imem_rsp_valid,
    input  logic [INSTR_W-1:0]   imem_rsp_data,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    output logic [INSTR_W-1:0]   instr_data,
    output logic [XLEN-1:0]      instr_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]          perf_stall_cnt,
    output logic [31:0]          perf_flush_cnt
`endif
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned SW = CW + 1;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    localparam int unsigned EW = $bits(entry_t);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   outst_q, outst_d;
    logic [CW-1:0]   discard_q, discard_d;
    logic [CW-1:0]   fifo_cnt;
    logic            fifo_valid;
    logic            req_fire, push, pop;
    entry_t          push_entry, head_entry;

    // A request is only issued if its response is guaranteed a buffer slot.
    assign imem_req_valid = ((SW'(outst_q) + SW'(fifo_cnt)) < SW'(DEPTH)) && !redirect_valid;
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign pop            = fifo_valid && instr_ready && !redirect_valid;

    always_comb begin
        fetch_pc_d       = fetch_pc_q;
        rsp_pc_d         = rsp_pc_q;
        discard_d        = discard_q;
        push             = 1'b0;
        push_entry.pc    = rsp_pc_q;
        push_entry.instr = imem_rsp_data;
        outst_d          = outst_q + CW'(req_fire) - CW'(imem_rsp_valid);
        if (redirect_valid) begin
            // Everything still in flight after this cycle belongs to the old path.
            fetch_pc_d = redirect_pc;
            rsp_pc_d   = redirect_pc;
            discard_d  = outst_d;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            if (imem_rsp_valid) begin
                if (discard_q != '0) begin
                    discard_d = discard_q - CW'(1);
                end else begin
                    push     = 1'b1;
                    rsp_pc_d = rsp_pc_q + XLEN'(4);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            outst_q    <= '0;
            discard_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
        end
    end

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (redirect_valid),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (pop),
        .valid_o (fifo_valid),
        .data_o  (head_entry),
        .count_o (fifo_cnt)
    );

    assign instr_valid = fifo_valid;
    assign instr_data  = head_entry.instr;
    assign instr_pc    = head_entry.pc;

`ifdef FETCH_PERF_EN
    logic [31:0] stall_q, flush_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (instr_ready && !fifo_valid && (stall_q != '1)) begin
                stall_q <= stall_q + 32'd1;
            end
            if (redirect_valid && (flush_q != '1)) begin
                flush_q <= flush_q + 32'd1;
            end
        end
    end

    assign perf_stall_cnt = stall_q;
    assign perf_flush_cnt = flush_q;
`endif

endmodule
